// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, issue scoreboard port, writeback port.
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              busy1;
  logic              busy2;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W:0]   pend_cnt;

  // Decode/writeback side drives addresses and data.
  modport master (
    output ra1, ra2, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
    input  rd1, rd2, busy1, busy2, pend_cnt
  );

  // Register file side.
  modport slave (
    input  ra1, ra2, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
    output rd1, rd2, busy1, busy2, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, optional hardwired
// zero register and a per-register pending bit for in-flight writebacks.
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NREG     = 8,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_d;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_d;
  logic              wb_legal;
  logic              iss_legal;

  // An address is usable if it names a real register and is not the zero register.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (32'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wb_legal  = bus.wb_en && addr_legal(bus.wb_addr);
  assign iss_legal = bus.iss_valid && addr_legal(bus.iss_rd);

  // Scoreboard next state: a new issue outranks a completing writeback.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREG; i++) begin
      if (iss_legal && (bus.iss_rd == ADDR_W'(i))) begin
        pend_d[i] = 1'b1;
      end else if (wb_legal && (bus.wb_addr == ADDR_W'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Popcount of the next pending vector so pend_cnt lines up with pend_q.
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(pend_d[i]);
    end
  end

  // Storage write and scoreboard update; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_legal && (bus.wb_addr == ADDR_W'(i))) begin
          regs_q[i] <= bus.wb_data;
        end
      end
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Read port 1: zero for unusable addresses, bypass on same-cycle writeback.
  always_comb begin
    bus.rd1   = '0;
    bus.busy1 = 1'b0;
    if (addr_legal(bus.ra1)) begin
      if (wb_legal && (bus.wb_addr == bus.ra1)) begin
        bus.rd1 = bus.wb_data;
      end else begin
        bus.rd1   = regs_q[bus.ra1];
        bus.busy1 = pend_q[bus.ra1];
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    bus.rd2   = '0;
    bus.busy2 = 1'b0;
    if (addr_legal(bus.ra2)) begin
      if (wb_legal && (bus.wb_addr == bus.ra2)) begin
        bus.rd2 = bus.wb_data;
      end else begin
        bus.rd2   = regs_q[bus.ra2];
        bus.busy2 = pend_q[bus.ra2];
      end
    end
  end

  assign bus.pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a queue-based scoreboard.
module tb_regfile_sb;

  logic clk;
  logic rst_n;

  regfile_sb_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .NREG(8), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bits: [4]=rd1 [3]=rd2 [2]=busy1 [1]=busy2 [0]=pend_cnt
  typedef struct packed {
    logic [4:0] mask;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       b1;
    logic       b2;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic drive(input logic rn, input logic [2:0] a1, input logic [2:0] a2,
                       input logic iv, input logic [2:0] ird,
                       input logic we, input logic [2:0] wa, input logic [7:0] wd);
    rst_n         = rn;
    bus.ra1       = a1;
    bus.ra2       = a2;
    bus.iss_valid = iv;
    bus.iss_rd    = ird;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] m,
                            input logic [7:0] e1, input logic [7:0] e2,
                            input logic eb1, input logic eb2, input logic [3:0] ec);
    exp_t e;
    e.mask = m; e.rd1 = e1; e.rd2 = e2; e.b1 = eb1; e.b2 = eb2; e.cnt = ec;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.mask[4]) begin
        n_cmp++;
        if (bus.rd1 !== e.rd1) begin
          n_bad++;
          $display("FAIL %s rd1: got %h want %h", nm, bus.rd1, e.rd1);
        end
      end
      if (e.mask[3]) begin
        n_cmp++;
        if (bus.rd2 !== e.rd2) begin
          n_bad++;
          $display("FAIL %s rd2: got %h want %h", nm, bus.rd2, e.rd2);
        end
      end
      if (e.mask[2]) begin
        n_cmp++;
        if (bus.busy1 !== e.b1) begin
          n_bad++;
          $display("FAIL %s busy1: got %b want %b", nm, bus.busy1, e.b1);
        end
      end
      if (e.mask[1]) begin
        n_cmp++;
        if (bus.busy2 !== e.b2) begin
          n_bad++;
          $display("FAIL %s busy2: got %b want %b", nm, bus.busy2, e.b2);
        end
      end
      if (e.mask[0]) begin
        n_cmp++;
        if (bus.pend_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL %s pend_cnt: got %0d want %0d", nm, bus.pend_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    tick();
    tick();

    // reset state
    drive(1'b1, 3'd3, 3'd7, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("reset", 5'b11111, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();

    // write bypass then storage
    drive(1'b1, 3'd2, 3'd7, 1'b0, 3'd0, 1'b1, 3'd2, 8'hA5);
    expect_out("wr_bypass", 5'b11111, 8'hA5, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 3'd2, 3'd7, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("wr_storage", 5'b10001, 8'hA5, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();

    // zero register ignores issue and write
    drive(1'b1, 3'd0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("r0_issue", 5'b10101, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 3'd0, 3'd2, 1'b0, 3'd0, 1'b1, 3'd0, 8'hFF);
    expect_out("r0_write", 5'b11101, 8'h00, 8'hA5, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 3'd0, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("r0_after", 5'b10101, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();

    // issue r4, then writeback resolves it
    drive(1'b1, 3'd4, 3'd2, 1'b1, 3'd4, 1'b0, 3'd0, 8'h00);
    expect_out("iss4_same", 5'b00101, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 3'd4, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("iss4_busy", 5'b10101, 8'h00, 8'h00, 1'b1, 1'b0, 4'd1);
    tick();
    drive(1'b1, 3'd4, 3'd2, 1'b0, 3'd0, 1'b1, 3'd4, 8'h3C);
    expect_out("wb4_bypass", 5'b10101, 8'h3C, 8'h00, 1'b0, 1'b0, 4'd1);
    tick();
    drive(1'b1, 3'd4, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("wb4_after", 5'b10101, 8'h3C, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();

    // simultaneous issue and writeback on pending r5
    drive(1'b1, 3'd5, 3'd2, 1'b1, 3'd5, 1'b0, 3'd0, 8'h00);
    tick();
    drive(1'b1, 3'd5, 3'd2, 1'b1, 3'd5, 1'b1, 3'd5, 8'h11);
    expect_out("r5_collide", 5'b10101, 8'h11, 8'h00, 1'b0, 1'b0, 4'd1);
    tick();
    drive(1'b1, 3'd5, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("r5_after", 5'b11111, 8'h11, 8'hA5, 1'b1, 1'b0, 4'd1);
    tick();

    // issue r1, r2, r6 back to back
    drive(1'b1, 3'd1, 3'd5, 1'b1, 3'd1, 1'b0, 3'd0, 8'h00);
    expect_out("iss1", 5'b00011, 8'h00, 8'h00, 1'b0, 1'b1, 4'd1);
    tick();
    drive(1'b1, 3'd1, 3'd5, 1'b1, 3'd2, 1'b0, 3'd0, 8'h00);
    expect_out("iss2", 5'b00111, 8'h00, 8'h00, 1'b1, 1'b1, 4'd2);
    tick();
    drive(1'b1, 3'd1, 3'd2, 1'b1, 3'd6, 1'b0, 3'd0, 8'h00);
    expect_out("iss6", 5'b00111, 8'h00, 8'h00, 1'b1, 1'b1, 4'd3);
    tick();
    drive(1'b1, 3'd1, 3'd6, 1'b0, 3'd0, 1'b1, 3'd1, 8'h77);
    expect_out("wb1_busy", 5'b10111, 8'h77, 8'h00, 1'b0, 1'b1, 4'd4);
    tick();

    // reset with a writeback in flight
    drive(1'b0, 3'd1, 3'd6, 1'b1, 3'd3, 1'b1, 3'd1, 8'h99);
    tick();
    drive(1'b1, 3'd1, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("post_rst", 5'b10111, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 3'd2, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("post_rst2", 5'b11111, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();

    // writeback to a non-pending register
    drive(1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3, 8'h5A);
    expect_out("wb_nopend", 5'b01011, 8'h00, 8'h5A, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    expect_out("wb_nopend2", 5'b01011, 8'h00, 8'h5A, 1'b0, 1'b0, 4'd0);
    tick();

    // drain the scoreboard with a bound
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
